command_queue_ctrl: RTL and testbench
=====================================

Name: command_queue_ctrl

Overview:
- Parametrised command buffer and issue sequencer between the host command interface and the GPU controller.
- Accepts decoded command/data pairs from the interface.
- Queues them in a FIFO of configurable depth and data width.
- Issues each entry to the controller only when the controller is idle and no frame is rendering; drives the RDY/#BSY flow control back to the host.
- Adds no-op filtering, reset-all flush, frame-update hold, watermark-based ready, and sticky overflow reporting.

Parameters:
- DATA_WIDTH, 16: width of data accompanying each command. Command width is fixed at 16.
- FIFO_DEPTH, 8: queue entries; must be a power of 2 and ≥ 4.
- READY_MARGIN, 2: readyBusy drops when fill ≥ FIFO_DEPTH − READY_MARGIN. Valid range 1..FIFO_DEPTH−1.

Ports:
- gpuClk  in  1  system clock (400 MHz); all logic on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- cmdValid  in  1  one-cycle strobe: cmdIn/dataIn valid, already synchronised to gpuClk
- cmdIn  in  16  command word (fields per GPU command format)
- dataIn  in  DATA_WIDTH  data word paired with cmdIn
- gpuBusyController  in  1  controller busy; 1 blocks issue
- frameRendering  in  1  frame render in progress; 1 blocks issue
- readyBusy  out  1  1 = host may send, 0 = busy
- gpuCmdValid  out  1  one-cycle strobe: gpuCommand/gpuData valid
- gpuCommand  out  16  issued command
- gpuData  out  DATA_WIDTH  issued data
- fillLevel  out  log2(FIFO_DEPTH)+1  current entry count
- overflowErr  out  1  sticky; set on write while full

Behaviour:
- Reset (rst = 0 at a clock edge):
  - readyBusy = 0, gpuCmdValid = 0, gpuCommand = 0, gpuData = 0, fillLevel = 0, overflowErr = 0.
  - FIFO pointers cleared; state = IDLE.
  - Applies mid-operation: a pending strobe is dropped and the FIFO contents are discarded.
  - readyBusy rises on the first edge after rst returns to 1.
- Write side (evaluated on cmdValid = 1):
  - cmdIn == 16'h0000 (no-op): discarded, never enqueued.
  - cmdIn[15:14] == 2'b11 and cmdIn[13:11] == 3'b000 (reset-all): FIFO flushed that cycle, then the reset-all entry is written as the sole entry (fillLevel = 1 next cycle). Any pop in the same cycle still issues normally.
  - Otherwise, if not full: enqueue {cmdIn, dataIn}.
  - If full: entry dropped, overflowErr ← 1. overflowErr clears only on reset.
- Simultaneous push and pop: both take effect; fillLevel unchanged. Pointers wrap modulo FIFO_DEPTH.
- readyBusy is registered: 1 iff fillLevel(next) < FIFO_DEPTH − READY_MARGIN and state ≠ FRAME_HOLD.
- State machine:
  - IDLE: if fillLevel > 0, gpuBusyController = 0 and frameRendering = 0:
    - pop head;
    - register it onto gpuCommand/gpuData;
    - gpuCmdValid = 1 for exactly one cycle;
    - go to GUARD.
  - GUARD: one cycle, no issue; absorbs the controller's busy-assert latency. Next state is FRAME_HOLD if the issued command was 16'h0001 (update frame), else IDLE.
  - FRAME_HOLD: no issue, readyBusy = 0. Wait for frameRendering = 1 (ARMED flag), then frameRendering = 0, then go to IDLE. Pushes still accepted while not full.
- Issue latency: entry present in an empty FIFO with the controller idle → gpuCmdValid two edges after the cmdValid edge (1 cycle enqueue, 1 cycle issue).
- gpuCommand/gpuData hold the last issued value between strobes.
- Maximum issue rate is one command per 2 cycles.

Test Plan:
- Reset, rst = 1, push cmd 16'h8801/data 16'h00AA with the controller idle → gpuCmdValid 2 cycles later with gpuCommand = 16'h8801, gpuData = 16'h00AA; fillLevel returns to 0; next issue is no sooner than 2 cycles later.
- Hold gpuBusyController = 1, push 8 distinct writes (FIFO_DEPTH = 8, READY_MARGIN = 2):
  - readyBusy falls once fillLevel reaches 6.
  - The 9th push sets overflowErr and is dropped.
  - Release busy → 8 commands issued in original order; readyBusy returns to 1 below 6.
- Push 16'h0000 three times → fillLevel stays 0, no gpuCmdValid.
- Busy held, 5 entries queued; push 16'hC000 → fillLevel = 1; on release only 16'hC000 is issued.
- Push 16'h0001 then 16'h8801:
  - 16'h0001 issues; readyBusy = 0 in FRAME_HOLD.
  - Raise frameRendering for 10 cycles, then drop it → 16'h8801 issues only after the drop.
- Assert rst = 0 while 4 entries are queued and in FRAME_HOLD → all outputs at reset values next edge; no stale issue after release.

Source files
------------

// File: rtl/command_queue_ctrl.sv
// Command FIFO and issue sequencer between the host command port and the GPU controller.
// Filters no-ops, flushes on reset-all, holds issue across frame updates.
module command_queue_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int READY_MARGIN = 2
) (
    input  logic                        gpuClk,
    input  logic                        rst,
    input  logic                        cmdValid,
    input  logic [15:0]                 cmdIn,
    input  logic [DATA_WIDTH-1:0]       dataIn,
    input  logic                        gpuBusyController,
    input  logic                        frameRendering,
    output logic                        readyBusy,
    output logic                        gpuCmdValid,
    output logic [15:0]                 gpuCommand,
    output logic [DATA_WIDTH-1:0]       gpuData,
    output logic [$clog2(FIFO_DEPTH):0] fillLevel,
    output logic                        overflowErr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 16 + DATA_WIDTH;
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] READY_LIMIT = CW'(FIFO_DEPTH - READY_MARGIN);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] GUARD      = 2'd1;
    localparam logic [1:0] FRAME_HOLD = 2'd2;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   countNext;
    logic [1:0]      state;
    logic [1:0]      stateNext;
    logic            armed;
    logic            armedNext;
    logic            isNoop;
    logic            isResetAll;
    logic            full;
    logic            canIssue;
    logic            pushNorm;
    logic            flushPush;
    logic            overflowSet;
    logic            readyNext;
    logic [EW-1:0]   head;

    assign isNoop     = (cmdIn == 16'h0000);
    assign isResetAll = (cmdIn[15:14] == 2'b11) && (cmdIn[13:11] == 3'b000);
    assign full       = (count == FULL_LEVEL);
    assign canIssue   = (state == IDLE) && (count != '0)
                        && !gpuBusyController && !frameRendering;
    assign pushNorm   = cmdValid && !isNoop && !isResetAll && !full;
    assign flushPush  = cmdValid && isResetAll;
    assign overflowSet = cmdValid && !isNoop && !isResetAll && full;
    assign head       = mem[rdPtr];
    assign fillLevel  = count;

    always_comb begin
        if (flushPush)
            countNext = CW'(1);
        else
            countNext = count + CW'(pushNorm) - CW'(canIssue);
    end

    always_comb begin
        stateNext = state;
        armedNext = armed;
        unique case (state)
            IDLE: begin
                if (canIssue)
                    stateNext = GUARD;
            end
            GUARD: begin
                // gpuCommand still holds the command issued one cycle ago
                stateNext = (gpuCommand == 16'h0001) ? FRAME_HOLD : IDLE;
                armedNext = 1'b0;
            end
            FRAME_HOLD: begin
                if (!armed) begin
                    if (frameRendering)
                        armedNext = 1'b1;
                end else if (!frameRendering) begin
                    stateNext = IDLE;
                    armedNext = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
                armedNext = 1'b0;
            end
        endcase
    end

    assign readyNext = (countNext < READY_LIMIT) && (stateNext != FRAME_HOLD);

    always_ff @(posedge gpuClk) begin
        if (!rst) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            state       <= IDLE;
            armed       <= 1'b0;
            readyBusy   <= 1'b0;
            gpuCmdValid <= 1'b0;
            gpuCommand  <= '0;
            gpuData     <= '0;
            overflowErr <= 1'b0;
        end else begin
            count       <= countNext;
            state       <= stateNext;
            armed       <= armedNext;
            readyBusy   <= readyNext;
            gpuCmdValid <= canIssue;
            if (pushNorm || flushPush)
                wrPtr <= wrPtr + AW'(1);
            // a flush drops everything behind the reset-all entry
            if (flushPush)
                rdPtr <= wrPtr;
            else if (canIssue)
                rdPtr <= rdPtr + AW'(1);
            if (canIssue) begin
                gpuCommand <= head[EW-1:DATA_WIDTH];
                gpuData    <= head[DATA_WIDTH-1:0];
            end
            if (overflowSet)
                overflowErr <= 1'b1;
        end
    end

    always_ff @(posedge gpuClk) begin
        if (rst && (pushNorm || flushPush))
            mem[wrPtr] <= {cmdIn, dataIn};
    end

endmodule

// File: tb/tb_command_queue_ctrl.sv
// Directed bench for command_queue_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_command_queue_ctrl;

    logic        gpuClk = 1'b0;
    logic        rst;
    logic        cmdValid;
    logic [15:0] cmdIn;
    logic [15:0] dataIn;
    logic        gpuBusyController;
    logic        frameRendering;
    logic        readyBusy;
    logic        gpuCmdValid;
    logic [15:0] gpuCommand;
    logic [15:0] gpuData;
    logic [3:0]  fillLevel;
    logic        overflowErr;

    int testsRun = 0;
    int testsFailed = 0;

    command_queue_ctrl #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(8),
        .READY_MARGIN(2)
    ) dut (
        .gpuClk(gpuClk),
        .rst(rst),
        .cmdValid(cmdValid),
        .cmdIn(cmdIn),
        .dataIn(dataIn),
        .gpuBusyController(gpuBusyController),
        .frameRendering(frameRendering),
        .readyBusy(readyBusy),
        .gpuCmdValid(gpuCmdValid),
        .gpuCommand(gpuCommand),
        .gpuData(gpuData),
        .fillLevel(fillLevel),
        .overflowErr(overflowErr)
    );

    always #5 gpuClk = ~gpuClk;

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge gpuClk);
        #1;
    endtask

    task automatic push(input logic [15:0] c, input logic [15:0] d);
        cmdValid = 1'b1;
        cmdIn = c;
        dataIn = d;
        step();
        cmdValid = 1'b0;
    endtask

    int issued;
    int firstCycle;
    logic [15:0] firstCmd;
    logic orderOk;

    initial begin
        rst = 1'b0;
        cmdValid = 1'b0;
        cmdIn = '0;
        dataIn = '0;
        gpuBusyController = 1'b0;
        frameRendering = 1'b0;
        step();
        step();
        checkVal("rst_ready", readyBusy, 0);
        checkVal("rst_valid", gpuCmdValid, 0);
        checkVal("rst_fill", fillLevel, 0);
        checkVal("rst_ovf", overflowErr, 0);
        checkVal("rst_cmd", gpuCommand, 0);
        rst = 1'b1;
        step();
        checkVal("ready_rise", readyBusy, 1);

        // single command latency
        push(16'h8801, 16'h00AA);
        checkVal("t1_fill1", fillLevel, 1);
        checkVal("t1_novalid", gpuCmdValid, 0);
        step();
        checkVal("t1_valid", gpuCmdValid, 1);
        checkVal("t1_cmd", gpuCommand, 16'h8801);
        checkVal("t1_data", gpuData, 16'h00AA);
        checkVal("t1_fill0", fillLevel, 0);
        step();
        checkVal("t1_guard", gpuCmdValid, 0);
        checkVal("t1_hold", gpuCommand, 16'h8801);

        // fill to full with controller busy
        gpuBusyController = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(16'h1000 + 16'(i), 16'h0100 + 16'(i));
            checkVal($sformatf("t2_fill%0d", i), fillLevel, i + 1);
            checkVal($sformatf("t2_ready%0d", i), readyBusy, (i + 1) < 6);
        end
        checkVal("t2_noovf", overflowErr, 0);
        push(16'h1FFF, 16'hFFFF);
        checkVal("t2_ovf", overflowErr, 1);
        checkVal("t2_fullfill", fillLevel, 8);
        gpuBusyController = 1'b0;
        issued = 0;
        orderOk = 1'b1;
        for (int c = 0; c < 40 && issued < 9; c++) begin
            step();
            if (gpuCmdValid) begin
                if (gpuCommand !== 16'h1000 + 16'(issued) ||
                    gpuData !== 16'h0100 + 16'(issued))
                    orderOk = 1'b0;
                issued++;
            end
        end
        checkVal("t2_issued", issued, 8);
        checkVal("t2_order", orderOk, 1);
        checkVal("t2_empty", fillLevel, 0);
        checkVal("t2_ready", readyBusy, 1);
        checkVal("t2_ovfsticky", overflowErr, 1);

        // no-op filtering
        issued = 0;
        for (int i = 0; i < 3; i++) begin
            push(16'h0000, 16'h1234);
            if (gpuCmdValid) issued++;
        end
        checkVal("t3_fill", fillLevel, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (gpuCmdValid) issued++;
        end
        checkVal("t3_noissue", issued, 0);

        // reset-all flush
        gpuBusyController = 1'b1;
        for (int i = 0; i < 5; i++)
            push(16'h2000 + 16'(i), 16'(i));
        checkVal("t4_fill5", fillLevel, 5);
        push(16'hC000, 16'h0055);
        checkVal("t4_fill1", fillLevel, 1);
        gpuBusyController = 1'b0;
        issued = 0;
        firstCmd = '0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (gpuCmdValid) begin
                if (issued == 0) firstCmd = gpuCommand;
                issued++;
            end
        end
        checkVal("t4_count", issued, 1);
        checkVal("t4_cmd", firstCmd, 16'hC000);

        // frame update hold
        push(16'h0001, 16'h0000);
        push(16'h8801, 16'h0077);
        checkVal("t5_valid", gpuCmdValid, 1);
        checkVal("t5_cmd", gpuCommand, 16'h0001);
        step();
        checkVal("t5_holdready", readyBusy, 0);
        frameRendering = 1'b1;
        issued = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gpuCmdValid) issued++;
        end
        checkVal("t5_blocked", issued, 0);
        checkVal("t5_ready_hold", readyBusy, 0);
        frameRendering = 1'b0;
        firstCycle = -1;
        for (int c = 0; c < 10 && firstCycle < 0; c++) begin
            step();
            if (gpuCmdValid) firstCycle = c;
        end
        checkVal("t5_issue_cycle", firstCycle, 1);
        checkVal("t5_cmd2", gpuCommand, 16'h8801);
        checkVal("t5_data2", gpuData, 16'h0077);

        // reset mid-operation in FRAME_HOLD
        step();
        step();
        push(16'h0001, 16'h0000);
        step();
        step();
        for (int i = 0; i < 4; i++)
            push(16'h3000 + 16'(i), 16'(i));
        checkVal("t6_fill4", fillLevel, 4);
        checkVal("t6_ready0", readyBusy, 0);
        rst = 1'b0;
        cmdValid = 1'b1;
        cmdIn = 16'h4444;
        step();
        cmdValid = 1'b0;
        checkVal("t6_fill", fillLevel, 0);
        checkVal("t6_ready", readyBusy, 0);
        checkVal("t6_valid", gpuCmdValid, 0);
        checkVal("t6_cmd", gpuCommand, 0);
        checkVal("t6_data", gpuData, 0);
        checkVal("t6_ovf", overflowErr, 0);
        rst = 1'b1;
        issued = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gpuCmdValid) issued++;
        end
        checkVal("t6_nostale", issued, 0);
        checkVal("t6_fillafter", fillLevel, 0);
        checkVal("t6_readyafter", readyBusy, 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
